// File: rtl/quant_pipe_pc.sv
// -----------------------------------------------------------------------------
// quant_pipe_pc
//
// Per-channel FP32-to-integer quantiser:
//   q = clamp(RNE(x * scale[ch]) + zp[ch])
// The product is never rounded to FP32; it is rounded once, directly to an
// integer, so results are exact for every input pair.
//
// Four-stage valid/ready pipeline (one sample per cycle, 4-cycle latency):
//   S1 decode/fetch : latch sample and table[in_ch], classify NaN/Inf/zero
//   S2 multiply     : exact 24x24 mantissa product, unbiased exponent
//   S3 convert      : shift to integer, round half to even, detect overflow
//   S4 offset/clamp : add zero point (asymmetric), clamp, drive outputs
// The whole pipeline freezes while the output is valid and not accepted.
//
// Parameters:
//   QW   - output width in bits (4..16)
//   CH_W - channel index width, NCH = 2**CH_W table entries
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   cfg_we/cfg_ch  - write table entry cfg_ch at the clock edge
//   cfg_scale      - FP32 inverse scale for that entry
//   cfg_zp         - unsigned zero point (asymmetric mode only)
//   cfg_asym       - 1 = asymmetric/unsigned output, 0 = symmetric/signed
//   in_valid/in_ready/in_data/in_ch    - FP32 sample input and its channel
//   out_valid/out_ready/out_q/out_sat/out_ch - quantised result, clamp or
//                    special-value flag, channel tag
//
// Optional feature (macro QUANT_SAT_CNT_EN):
//   sat_cnt_clr    - synchronous clear of the saturation counter (priority)
//   sat_cnt        - 16-bit saturating count of delivered results with
//                    out_sat=1
// -----------------------------------------------------------------------------
module quant_pipe_pc #(
    parameter int QW   = 8,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [31:0]     cfg_scale,
    input  logic [QW-1:0]   cfg_zp,
    input  logic            cfg_asym,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [CH_W-1:0] in_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QW-1:0]   out_q,
    output logic            out_sat,
    output logic [CH_W-1:0] out_ch
`ifdef QUANT_SAT_CNT_EN
    ,
    input  logic            sat_cnt_clr,
    output logic [15:0]     sat_cnt
`endif
);

    localparam int NCH = 2 ** CH_W;
    localparam logic [31:0] ONE_F32 = 32'h3F80_0000;

    // Magnitude used for any overflow or infinity; it lies outside every
    // clamp range, so S4 clamps it to the correct bound for either sign.
    localparam logic [QW+1:0] SAT_MAG = {1'b1, {(QW + 1){1'b0}}};

    localparam logic signed [QW+2:0] SYM_MAX  = (QW + 3)'((1 << (QW - 1)) - 1);
    localparam logic signed [QW+2:0] SYM_MIN  = -SYM_MAX;
    localparam logic signed [QW+2:0] ASYM_MAX = (QW + 3)'((1 << QW) - 1);

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic            asym;
        logic [QW-1:0]   zp;
        logic            sign;
        logic            nan;
        logic            inf;
        logic            zero;
        logic [7:0]      ea;
        logic [7:0]      eb;
        logic [23:0]     ma;
        logic [23:0]     mb;
    } s1_t;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic            asym;
        logic [QW-1:0]   zp;
        logic            sign;
        logic            nan;
        logic            inf;
        logic            zero;
        logic [47:0]     prod;
        logic [9:0]      e;      // signed: ea + eb - 254
    } s2_t;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic            asym;
        logic [QW-1:0]   zp;
        logic            sign;
        logic            nan;
        logic [QW+1:0]   mag;
    } s3_t;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic [QW-1:0]   q;
        logic            sat;
    } s4_t;

    // ------------------------------------------------------------------
    // Channel table
    // ------------------------------------------------------------------
    logic [31:0]   scale_tab_q [NCH];
    logic [31:0]   scale_tab_d [NCH];
    logic [QW-1:0] zp_tab_q    [NCH];
    logic [QW-1:0] zp_tab_d    [NCH];
    logic          asym_tab_q  [NCH];
    logic          asym_tab_d  [NCH];

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        scale_tab_d = scale_tab_q;
        zp_tab_d    = zp_tab_q;
        asym_tab_d  = asym_tab_q;
        if (cfg_we) begin
            scale_tab_d[cfg_ch] = cfg_scale;
            zp_tab_d[cfg_ch]    = cfg_zp;
            asym_tab_d[cfg_ch]  = cfg_asym;
        end
    end

    // NOTE: the table is a handful of flops, not a RAM, and must come out of
    // reset as identity scale / symmetric, so it is reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                scale_tab_q[i] <= ONE_F32;
                zp_tab_q[i]    <= '0;
                asym_tab_q[i]  <= 1'b0;
            end
        end else begin
            scale_tab_q <= scale_tab_d;
            zp_tab_q    <= zp_tab_d;
            asym_tab_q  <= asym_tab_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    s3_t s3_q, s3_d;
    s4_t s4_q, s4_d;

    logic stall;
    assign stall    = s4_q.valid & ~out_ready;
    assign in_ready = ~stall;

    // ------------------------------------------------------------------
    // S1: decode and fetch. The table is read before this edge's write
    // lands, so a same-cycle write to the sample's channel is not seen.
    // ------------------------------------------------------------------
    logic [31:0] fetch_scale;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        any_nan;

    always_comb begin
        fetch_scale = scale_tab_q[in_ch];
        // Denormals (exp = 0) collapse to zero.
        a_zero  = (in_data[30:23] == 8'h00);
        a_inf   = (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
        a_nan   = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
        b_zero  = (fetch_scale[30:23] == 8'h00);
        b_inf   = (fetch_scale[30:23] == 8'hFF) && (fetch_scale[22:0] == 23'd0);
        b_nan   = (fetch_scale[30:23] == 8'hFF) && (fetch_scale[22:0] != 23'd0);
        // Inf x 0 has no meaningful value and is folded into NaN.
        any_nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);

        s1_d = s1_q;
        if (!stall) begin
            s1_d.valid = in_valid;
            s1_d.ch    = in_ch;
            s1_d.asym  = asym_tab_q[in_ch];
            s1_d.zp    = zp_tab_q[in_ch];
            s1_d.sign  = in_data[31] ^ fetch_scale[31];
            s1_d.nan   = any_nan;
            s1_d.inf   = (a_inf | b_inf) & ~any_nan;
            s1_d.zero  = (a_zero | b_zero) & ~any_nan;
            s1_d.ea    = in_data[30:23];
            s1_d.eb    = fetch_scale[30:23];
            s1_d.ma    = {1'b1, in_data[22:0]};
            s1_d.mb    = {1'b1, fetch_scale[22:0]};
        end
    end

    // ------------------------------------------------------------------
    // S2: exact multiply. Product value = prod * 2^(e - 46).
    // ------------------------------------------------------------------
    always_comb begin
        s2_d = s2_q;
        if (!stall) begin
            s2_d.valid = s1_q.valid;
            s2_d.ch    = s1_q.ch;
            s2_d.asym  = s1_q.asym;
            s2_d.zp    = s1_q.zp;
            s2_d.sign  = s1_q.sign;
            s2_d.nan   = s1_q.nan;
            s2_d.inf   = s1_q.inf;
            s2_d.zero  = s1_q.zero;
            s2_d.prod  = s1_q.ma * s1_q.mb;
            s2_d.e     = {2'b00, s1_q.ea} + {2'b00, s1_q.eb} - 10'd254;
        end
    end

    // ------------------------------------------------------------------
    // S3: integer conversion with a single round-half-to-even step.
    // Right shift of 46 - e; the 48 bits shifted out form guard + sticky.
    // A shift of 0 or less leaves the value >= 2^46, always an overflow.
    // ------------------------------------------------------------------
    logic signed [10:0] sh;
    logic [6:0]         shamt;
    logic [95:0]        shifted;
    logic [47:0]        int_part;
    logic               guard, sticky, rnd_up;
    logic [48:0]        rounded;
    logic               too_big;

    always_comb begin
        sh       = 11'sd46 - $signed({s2_q.e[9], s2_q.e});
        // Shifts of 96 or more flush everything, including the guard bit.
        shamt    = (sh > 11'sd96) ? 7'd96 : sh[6:0];
        shifted  = {s2_q.prod, 48'd0} >> shamt;
        int_part = shifted[95:48];
        guard    = shifted[47];
        sticky   = |shifted[46:0];
        rnd_up   = guard & (sticky | int_part[0]);
        rounded  = {1'b0, int_part} + {48'd0, rnd_up};
        too_big  = (sh <= 11'sd0) || (|rounded[48:QW+1]);

        s3_d = s3_q;
        if (!stall) begin
            s3_d.valid = s2_q.valid;
            s3_d.ch    = s2_q.ch;
            s3_d.asym  = s2_q.asym;
            s3_d.zp    = s2_q.zp;
            s3_d.sign  = s2_q.sign;
            s3_d.nan   = s2_q.nan;
            if (s2_q.nan || s2_q.zero) begin
                s3_d.mag = '0;
            end else if (s2_q.inf || too_big) begin
                s3_d.mag = SAT_MAG;
            end else begin
                s3_d.mag = rounded[QW+1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // S4: apply sign and zero point, then clamp to the mode's range.
    // ------------------------------------------------------------------
    logic signed [QW+2:0] v_mag;
    logic signed [QW+2:0] v_off;
    logic signed [QW+2:0] lo_bound;
    logic signed [QW+2:0] hi_bound;

    always_comb begin
        v_mag    = $signed({1'b0, s3_q.mag});
        v_off    = s3_q.sign ? -v_mag : v_mag;
        if (s3_q.asym) begin
            v_off = v_off + $signed({3'b000, s3_q.zp});
        end
        lo_bound = s3_q.asym ? '0       : SYM_MIN;
        hi_bound = s3_q.asym ? ASYM_MAX : SYM_MAX;

        s4_d = s4_q;
        if (!stall) begin
            s4_d.valid = s3_q.valid;
            s4_d.ch    = s3_q.ch;
            if (s3_q.nan) begin
                s4_d.q   = s3_q.asym ? s3_q.zp : '0;
                s4_d.sat = 1'b1;
            end else if (v_off > hi_bound) begin
                s4_d.q   = hi_bound[QW-1:0];
                s4_d.sat = 1'b1;
            end else if (v_off < lo_bound) begin
                s4_d.q   = lo_bound[QW-1:0];
                s4_d.sat = 1'b1;
            end else begin
                s4_d.q   = v_off[QW-1:0];
                s4_d.sat = 1'b0;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every stage samples the previous stage's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            s4_q <= s4_d;
        end
    end

    assign out_valid = s4_q.valid;
    assign out_q     = s4_q.q;
    assign out_sat   = s4_q.sat;
    assign out_ch    = s4_q.ch;

`ifdef QUANT_SAT_CNT_EN
    // ------------------------------------------------------------------
    // Saturation counter: counts delivered results flagged out_sat.
    // ------------------------------------------------------------------
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (s4_q.valid && out_ready && s4_q.sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_quant_pipe_pc.sv
// -----------------------------------------------------------------------------
// tb_quant_pipe_pc
//
// Directed testbench for quant_pipe_pc (QW=8, CH_W=2). Each test task drives
// its own vectors and compares the DUT outputs against hand-computed values.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_quant_pipe_pc;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_scale;
    logic [7:0]  cfg_zp;
    logic        cfg_asym;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_q;
    logic        out_sat;
    logic [1:0]  out_ch;
`ifdef QUANT_SAT_CNT_EN
    logic        sat_cnt_clr;
    logic [15:0] sat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    quant_pipe_pc #(.QW(8), .CH_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_scale (cfg_scale),
        .cfg_zp    (cfg_zp),
        .cfg_asym  (cfg_asym),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_sat   (out_sat),
        .out_ch    (out_ch)
`ifdef QUANT_SAT_CNT_EN
        ,
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Write one table entry.
    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] scl,
                             input logic [7:0] zp, input logic asym);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_scale = scl; cfg_zp = zp; cfg_asym = asym;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Send one sample (optionally writing table[ch] in the same cycle with
    // scale scl, zp 0, symmetric) and collect its result. lat = number of
    // rising edges from the accepting edge up to the one that shows the
    // result; -1 if no result arrives within the budget.
    task automatic run_one(input logic [31:0] d, input logic [1:0] ch,
                           input logic do_cfg, input logic [31:0] scl,
                           output logic [7:0] q, output logic s,
                           output logic [1:0] oc, output int lat);
        q = 'x; s = 1'bx; oc = 'x; lat = -1;
        @(negedge clk);
        out_ready = 1'b1;
        in_data = d; in_ch = ch; in_valid = 1'b1;
        if (do_cfg) begin
            cfg_we = 1'b1; cfg_ch = ch; cfg_scale = scl; cfg_zp = 8'd0; cfg_asym = 1'b0;
        end
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            cfg_we   = 1'b0;
            if (out_valid) begin
                lat = n; q = out_q; s = out_sat; oc = out_ch;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_q !== 8'h00 || out_sat !== 1'b0 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b q=%h s=%b ch=%0d expected v=0 q=00 s=0 ch=0",
                     out_valid, out_q, out_sat, out_ch);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sym_round();
        logic [31:0] din [8];
        logic [7:0]  eq  [8];
        logic        es  [8];
        logic [7:0]  q;
        logic        s;
        logic [1:0]  oc;
        int          lat;
        // 2.5, 3.5, -2.5, 0.5, -0.0, 127.0, -127.0, 127.5
        din = '{32'h40200000, 32'h40600000, 32'hC0200000, 32'h3F000000,
                32'h80000000, 32'h42FE0000, 32'hC2FE0000, 32'h42FF0000};
        eq  = '{8'h02, 8'h04, 8'hFE, 8'h00, 8'h00, 8'h7F, 8'h81, 8'h7F};
        es  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_one(din[i], 2'd0, 1'b0, 32'h0, q, s, oc, lat);
            checks++;
            if (q !== eq[i] || s !== es[i]) begin
                errors++;
                $display("FAIL sym_round[%0d]: got q=%h s=%b expected q=%h s=%b", i, q, s, eq[i], es[i]);
            end
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL sym_latency[%0d]: got %0d expected 4", i, lat);
            end
        end
    endtask

    task automatic test_sym_clamp();
        logic [7:0] q;
        logic       s;
        logic [1:0] oc;
        int         lat;
        run_one(32'h43480000, 2'd0, 1'b0, 32'h0, q, s, oc, lat);   // 200.0
        checks++;
        if (q !== 8'h7F || s !== 1'b1) begin
            errors++;
            $display("FAIL sym_clamp_pos: got q=%h s=%b expected q=7f s=1", q, s);
        end
        run_one(32'hC3960000, 2'd0, 1'b0, 32'h0, q, s, oc, lat);   // -300.0
        checks++;
        if (q !== 8'h81 || s !== 1'b1) begin
            errors++;
            $display("FAIL sym_clamp_neg: got q=%h s=%b expected q=81 s=1", q, s);
        end
    endtask

    task automatic test_asym();
        logic [31:0] din [3];
        logic [7:0]  eq  [3];
        logic        es  [3];
        logic [7:0]  q;
        logic        s;
        logic [1:0]  oc;
        int          lat;
        cfg_write(2'd1, 32'h3F000000, 8'd128, 1'b1);   // scale 0.5, zp 128
        din = '{32'h41200000, 32'hC3960000, 32'h43C80000};   // 10, -300, 400
        eq  = '{8'd133, 8'd0, 8'd255};
        es  = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_one(din[i], 2'd1, 1'b0, 32'h0, q, s, oc, lat);
            checks++;
            if (q !== eq[i] || s !== es[i] || oc !== 2'd1) begin
                errors++;
                $display("FAIL asym[%0d]: got q=%0d s=%b ch=%0d expected q=%0d s=%b ch=1",
                         i, q, s, oc, eq[i], es[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] din [3];
        logic [7:0]  eq  [3];
        logic        es  [3];
        logic [7:0]  q;
        logic        s;
        logic [1:0]  oc;
        int          lat;
        din = '{32'h7FC00000, 32'h7F800000, 32'h00000001};   // NaN, +Inf, denormal
        eq  = '{8'd128, 8'd255, 8'd128};
        es  = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_one(din[i], 2'd1, 1'b0, 32'h0, q, s, oc, lat);
            checks++;
            if (q !== eq[i] || s !== es[i]) begin
                errors++;
                $display("FAIL special[%0d]: got q=%0d s=%b expected q=%0d s=%b", i, q, s, eq[i], es[i]);
            end
        end
        // -Inf in symmetric mode on ch0 clamps to the negative bound.
        run_one(32'hFF800000, 2'd0, 1'b0, 32'h0, q, s, oc, lat);
        checks++;
        if (q !== 8'h81 || s !== 1'b1) begin
            errors++;
            $display("FAIL special_neg_inf: got q=%h s=%b expected q=81 s=1", q, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [8];
        int          sent = 0;
        int          got  = 0;
        logic        exp_rdy;
        vec = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};   // 1..8
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_ch     = 2'd0;
            in_valid  = (sent < 8);
            if (sent < 8) in_data = vec[sent];
            #1;
            exp_rdy = !(cyc >= 6 && cyc <= 8);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL stream_in_ready[cyc %0d]: got %b expected %b", cyc, in_ready, exp_rdy);
            end
            if (cyc >= 6 && cyc <= 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_q !== 8'd3) begin
                    errors++;
                    $display("FAIL stream_hold[cyc %0d]: got v=%b q=%0d expected v=1 q=3",
                             cyc, out_valid, out_q);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_q !== 8'(got + 1)) begin
                    errors++;
                    $display("FAIL stream_order[%0d]: got q=%0d expected %0d", got, out_q, got + 1);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        checks++;
        if (got !== 8) begin
            errors++;
            $display("FAIL stream_count: got %0d results expected 8", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_extra[%0d]: got out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_cfg_same_cycle();
        logic [7:0] q;
        logic       s;
        logic [1:0] oc;
        int         lat;
        // Write ch2 scale 2.0 in the cycle that accepts a ch2 sample of 3.0.
        run_one(32'h40400000, 2'd2, 1'b1, 32'h40000000, q, s, oc, lat);
        checks++;
        if (q !== 8'd3 || s !== 1'b0 || oc !== 2'd2) begin
            errors++;
            $display("FAIL cfg_old_entry: got q=%0d s=%b ch=%0d expected q=3 s=0 ch=2", q, s, oc);
        end
        run_one(32'h40400000, 2'd2, 1'b0, 32'h0, q, s, oc, lat);
        checks++;
        if (q !== 8'd6 || s !== 1'b0) begin
            errors++;
            $display("FAIL cfg_new_entry: got q=%0d s=%b expected q=6 s=0", q, s);
        end
    endtask

`ifdef QUANT_SAT_CNT_EN
    task automatic test_sat_cnt();
        logic [7:0] q;
        logic       s;
        logic [1:0] oc;
        int         lat;
        @(negedge clk);
        sat_cnt_clr = 1'b1;
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_cnt_clr: got %0d expected 0", sat_cnt);
        end
        run_one(32'h43480000, 2'd0, 1'b0, 32'h0, q, s, oc, lat);   // sat
        run_one(32'hC3960000, 2'd0, 1'b0, 32'h0, q, s, oc, lat);   // sat
        run_one(32'h40200000, 2'd0, 1'b0, 32'h0, q, s, oc, lat);   // no sat
        @(negedge clk);
        checks++;
        if (sat_cnt !== 16'd2) begin
            errors++;
            $display("FAIL sat_cnt_count: got %0d expected 2", sat_cnt);
        end
    endtask
`endif

    task automatic test_reset_mid_stream();
        logic [7:0] q;
        logic       s;
        logic [1:0] oc;
        int         lat;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1; in_ch = 2'd0; in_data = 32'h3F800000;
        end
        #2;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_valid: got out_valid=%b expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_q !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: got v=%b q=%h expected v=0 q=00", out_valid, out_q);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_dropped[%0d]: got out_valid=%b expected 0", i, out_valid);
            end
        end
        // ch2 back to scale 1.0, ch1 back to symmetric / zp 0.
        run_one(32'h40400000, 2'd2, 1'b0, 32'h0, q, s, oc, lat);
        checks++;
        if (q !== 8'd3 || s !== 1'b0) begin
            errors++;
            $display("FAIL rst_table_ch2: got q=%0d s=%b expected q=3 s=0", q, s);
        end
        run_one(32'hC1200000, 2'd1, 1'b0, 32'h0, q, s, oc, lat);   // -10.0
        checks++;
        if (q !== 8'hF6 || s !== 1'b0) begin
            errors++;
            $display("FAIL rst_table_ch1: got q=%h s=%b expected q=f6 s=0", q, s);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_scale = '0;
        cfg_zp    = '0;
        cfg_asym  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ch     = '0;
        out_ready = 1'b1;
`ifdef QUANT_SAT_CNT_EN
        sat_cnt_clr = 1'b0;
`endif
        test_reset();
        test_sym_round();
        test_sym_clamp();
        test_asym();
        test_specials();
        test_back_to_back();
        test_cfg_same_cycle();
`ifdef QUANT_SAT_CNT_EN
        test_sat_cnt();
`endif
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
